// File: rtl/adder_err_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_err_sched                                            |
// | Description : Drives operand pairs to an approximate adder and gathers   |
// |               error metrics (error count, max and summed distance).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module adder_err_sched #(
   parameter int unsigned W    = 16,
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          mode,
   input  logic [31:0]   n_samples,
   input  logic          abort,
   output logic [W-1:0]  op_a,
   output logic [W-1:0]  op_b,
   input  logic [W:0]    approx_sum,
   output logic          busy,
   output logic          result_valid,
   input  logic          result_ready,
   output logic [31:0]   err_count,
   output logic [W:0]    max_ed,
   output logic [47:0]   sum_ed
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_RUN    = 2'd1;
   localparam logic [1:0]  S_DRAIN  = 2'd2;
   localparam logic [1:0]  S_REPORT = 2'd3;
   localparam logic [31:0] C_TAPS   = 32'h80200003;

   logic [1:0]   r_state;
   logic         r_mode;
   logic [31:0]  r_remaining;
   logic [31:0]  r_cnt;
   logic [31:0]  r_lfsr;

   // Compare stage: the pair on the outputs plus the adder's answer for it
   logic         r_pv;
   logic [W-1:0] r_pa;
   logic [W-1:0] r_pb;
   logic [W:0]   r_psum;

   logic [31:0]  w_first;
   logic [31:0]  w_word;
   logic [W:0]   w_exact;
   logic [W:0]   w_ed;
   logic [48:0]  w_sum_ext;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? C_TAPS : 32'h0);
   endfunction

   assign w_first   = mode ? SEED : 32'h0;
   assign w_word    = r_mode ? r_lfsr : r_cnt;
   assign w_exact   = {1'b0, r_pa} + {1'b0, r_pb};
   assign w_ed      = (w_exact >= r_psum) ? (w_exact - r_psum) : (r_psum - w_exact);
   assign w_sum_ext = {1'b0, sum_ed} + 49'(w_ed);

   assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign result_valid = (r_state == S_REPORT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= 1'b0;
         r_remaining <= 32'h0;
         r_cnt       <= 32'h0;
         r_lfsr      <= SEED;
         r_pv        <= 1'b0;
         r_pa        <= '0;
         r_pb        <= '0;
         r_psum      <= '0;
         op_a        <= '0;
         op_b        <= '0;
         err_count   <= 32'h0;
         max_ed      <= '0;
         sum_ed      <= 48'h0;
      end else begin
         r_pv <= 1'b0;

         if (r_pv) begin
            if ((w_ed != '0) && (err_count != 32'hFFFF_FFFF))
               err_count <= err_count + 32'd1;
            if (w_ed > max_ed)
               max_ed <= w_ed;
            sum_ed <= w_sum_ext[48] ? 48'hFFFF_FFFF_FFFF : w_sum_ext[47:0];
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode      <= mode;
                  r_remaining <= n_samples;
                  err_count   <= 32'h0;
                  max_ed      <= '0;
                  sum_ed      <= 48'h0;
                  // The first pair goes out on the accepting edge itself
                  if (n_samples == 32'h0) begin
                     r_cnt   <= 32'h0;
                     r_lfsr  <= SEED;
                     r_state <= S_REPORT;
                  end else begin
                     op_a    <= w_first[W-1:0];
                     op_b    <= w_first[2*W-1:W];
                     r_cnt   <= mode ? 32'h0 : 32'h1;
                     r_lfsr  <= mode ? lfsr_next(SEED) : SEED;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_pv   <= 1'b1;
                  r_pa   <= op_a;
                  r_pb   <= op_b;
                  r_psum <= approx_sum;
                  if (r_remaining == 32'd1) begin
                     r_state <= S_DRAIN;
                  end else begin
                     op_a        <= w_word[W-1:0];
                     op_b        <= w_word[2*W-1:W];
                     r_remaining <= r_remaining - 32'd1;
                     if (r_mode)
                        r_lfsr <= lfsr_next(r_lfsr);
                     else
                        r_cnt <= r_cnt + 32'd1;
                  end
               end
            end
            S_DRAIN: begin
               r_state <= abort ? S_IDLE : S_REPORT;
            end
            S_REPORT: begin
               if (result_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_err_sched.sv
`default_nettype none
// Testbench for adder_err_sched: the bench plays the approximate adder and
// scores operand sequences, latency and metrics against its own model.
module tb_adder_err_sched;
   localparam int          W    = 16;
   localparam logic [31:0] SEED = 32'h1;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          start        = 1'b0;
   logic          mode         = 1'b0;
   logic          abort        = 1'b0;
   logic          result_ready = 1'b0;
   logic [31:0]   n_samples    = 32'h0;
   logic [1:0]    asel         = 2'd0;
   logic [W-1:0]  op_a, op_b;
   logic [W:0]    approx_sum;
   logic          busy, result_valid;
   logic [31:0]   err_count;
   logic [W:0]    max_ed;
   logic [47:0]   sum_ed;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] pq[$];

   typedef struct {
      logic        md;
      int unsigned n;
      logic [1:0]  sel;
      bit          use_tab;
      longint      e_err;
      longint      e_max;
      longint      e_sum;
   } vec_t;

   vec_t vecs[7];

   adder_err_sched #(.W(W), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .n_samples(n_samples), .abort(abort), .op_a(op_a), .op_b(op_b),
      .approx_sum(approx_sum), .busy(busy), .result_valid(result_valid),
      .result_ready(result_ready), .err_count(err_count), .max_ed(max_ed),
      .sum_ed(sum_ed)
   );

   always #5 clk = ~clk;

   // 0 exact, 1 constant zero, 2 lower-part-OR (4 bits), 3 exact with LSB flipped
   function automatic logic [16:0] approx_fn(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] ex;
      ex = {1'b0, a} + {1'b0, b};
      case (sel)
         2'd0:    return ex;
         2'd1:    return 17'h0;
         2'd2:    return {({1'b0, a[15:4]} + {1'b0, b[15:4]}), (a[3:0] | b[3:0])};
         default: return ex ^ 17'h1;
      endcase
   endfunction

   always_comb approx_sum = approx_fn(asel, op_a, op_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model(input vec_t v, output longint e_err, output longint e_max, output longint e_sum);
      logic [31:0] g_c, g_l, w;
      logic [16:0] ex, ap;
      longint ed;
      g_c = 32'h0; g_l = SEED;
      e_err = 0; e_max = 0; e_sum = 0;
      for (int unsigned k = 0; k < v.n; k++) begin
         w = v.md ? g_l : g_c;
         pq.push_back(w);
         ex = {1'b0, w[15:0]} + {1'b0, w[31:16]};
         ap = approx_fn(v.sel, w[15:0], w[31:16]);
         ed = (ex >= ap) ? longint'(ex) - longint'(ap) : longint'(ap) - longint'(ex);
         if (ed != 0) e_err++;
         if (ed > e_max) e_max = ed;
         e_sum += ed;
         g_c = g_c + 32'd1;
         g_l = (g_l >> 1) ^ (g_l[0] ? TAPS : 32'h0);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      longint m_err, m_max, m_sum;
      logic [31:0] w;
      int cyc;
      int exp_lat;
      pq.delete();
      model(v, m_err, m_max, m_sum);
      if (v.use_tab) begin
         m_err = v.e_err; m_max = v.e_max; m_sum = v.e_sum;
      end
      mode = v.md; n_samples = v.n; asel = v.sel; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      if (v.n == 0) check({tag, "_busy_idle"}, busy, 0);
      for (int unsigned k = 0; k < v.n; k++) begin
         w = pq.pop_front();
         if (k == 0) check({tag, "_busy_run"}, busy, 1);
         check($sformatf("%s_pair%0d", tag, k), {op_b, op_a}, w);
         step();
         cyc++;
      end
      while (!result_valid && cyc < int'(v.n) + 20) begin
         step();
         cyc++;
      end
      exp_lat = (v.n == 0) ? 1 : int'(v.n) + 2;
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_err_count"}, err_count, m_err);
      check({tag, "_max_ed"}, max_ed, m_max);
      check({tag, "_sum_ed"}, sum_ed, m_sum);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check({tag, "_valid_drop"}, result_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1000, 2'd0, 1'b1, 0, 0, 0};
      vecs[1] = '{1'b0, 4,    2'd1, 1'b1, 3, 3, 6};
      vecs[2] = '{1'b0, 0,    2'd1, 1'b1, 0, 0, 0};
      vecs[3] = '{1'b1, 1,    2'd3, 1'b1, 1, 1, 1};
      vecs[4] = '{1'b0, 20,   2'd3, 1'b0, 0, 0, 0};
      vecs[5] = '{1'b1, 40,   2'd2, 1'b0, 0, 0, 0};
      vecs[6] = '{1'b1, 16,   2'd1, 1'b0, 0, 0, 0};

      repeat (3) step();
      check("rst_op_a", op_a, 0);
      check("rst_op_b", op_b, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_err", err_count, 0);
      check("rst_max", max_ed, 0);
      check("rst_sum", sum_ed, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Abort five cycles into a 100-sample run
      asel = 2'd3; mode = 1'b0; n_samples = 100; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", result_valid, 0);
      check("abort_partial", (err_count >= 1 && err_count <= 5) ? 1 : 0, 1);
      repeat (3) step();
      check("abort_no_report", result_valid, 0);

      // Abort coinciding with the last-sample transition
      n_samples = 3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_last_busy", busy, 0);
      repeat (3) step();
      check("abort_last_no_report", result_valid, 0);
      run_vec('{1'b0, 3, 2'd0, 1'b1, 0, 0, 0}, "post_abort");

      // REPORT held with ready low; start and abort must be ignored
      mode = 1'b0; n_samples = 4; asel = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("stall_enter", result_valid, 1);
      for (int k = 0; k < 10; k++) begin
         start = k[0]; abort = (k == 3); mode = 1'b1; n_samples = 7;
         step();
         check($sformatf("stall%0d_valid", k), result_valid, 1);
         check($sformatf("stall%0d_busy", k), busy, 0);
         check($sformatf("stall%0d_err", k), err_count, 3);
         check($sformatf("stall%0d_max", k), max_ed, 3);
         check($sformatf("stall%0d_sum", k), sum_ed, 6);
      end
      start = 1'b0; abort = 1'b0; result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check("stall_release_valid", result_valid, 0);
      check("stall_release_busy", busy, 0);

      // Reset in the middle of a random run
      mode = 1'b1; n_samples = 100; asel = 2'd3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_op_b", op_b, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", result_valid, 0);
      check("mid_rst_err", err_count, 0);
      check("mid_rst_max", max_ed, 0);
      check("mid_rst_sum", sum_ed, 0);
      rst_n = 1'b1;
      run_vec('{1'b1, 5, 2'd2, 1'b0, 0, 0, 0}, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
